ddma_rx_engine: RTL
===================

# ddma_rx_engine

Receive-side DMA engine for a processing element's NoC local port. It is the counterpart of the DDMA transmit path. It accepts flits from the router's local output and parses the header flit and the size flit. It writes the whole packet into a fixed receive buffer in local memory, then holds the packet until the CPU acknowledges it.

## Interface
Parameters:
- FLIT_WIDTH, 32: flit and memory data width.
- ADDRESS, 0: own router coordinate as (X << FLIT_WIDTH/4) | Y, occupying FLIT_WIDTH/2 bits.
- ADDR_WIDTH, 16: memory address width.
- BUF_BASE, 'h0: word address of the receive buffer.
- BUF_DEPTH, 64: receive buffer capacity in flits.

Ports:
- clock  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- data_i  in  FLIT_WIDTH  flit from the router local port.
- rx_i  in  1  flit valid.
- credit_o  out  1  ready; a flit transfers on a cycle where rx_i && credit_o.
- mem_wb_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_WIDTH  memory write address.
- mem_data_o  out  FLIT_WIDTH  memory write data.
- recv_done_o  out  1  a complete packet is in the buffer.
- recv_src_o  out  FLIT_WIDTH/2  source XY field of the buffered packet.
- recv_nflits_o  out  FLIT_WIDTH  total flits written (header + size + payload).
- drop_o  out  1  one-cycle pulse when a packet has been discarded.
- recv_ack_i  in  1  CPU releases the buffer.

## Operation
- Packet format:
  - flit 0 = {src_xy, dst_xy}; src_xy is data_i[FLIT_WIDTH-1:FLIT_WIDTH/2], and each XY field is {X, Y} of FLIT_WIDTH/4 bits each.
  - flit 1 = N, the number of payload flits that follow.
  - Total length is N+2 flits.
- States:
  - IDLE: on accept, go to SIZE and write the header at BUF_BASE. With DDMA_RX_DEST_CHECK_EN and dst_xy != ADDRESS, go to DROP_SIZE instead and do not write.
  - SIZE: on accept, write the flit at BUF_BASE+1 and latch N.
    - N == 0: go to DONE.
    - N+2 > BUF_DEPTH: go to DROP_BODY with count N.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD: each accepted flit is written at BUF_BASE+2+k for k = 0..N-1. After the N-th flit, go to DONE.
  - DONE: credit_o=0 and recv_done_o=1. When recv_ack_i=1, go to IDLE.
  - DROP_SIZE: accept the size flit without writing. If N == 0, go to IDLE and pulse drop_o. Otherwise latch N and go to DROP_BODY.
  - DROP_BODY: consume N flits without writing. On the last flit, pulse drop_o and go to IDLE.
- Counter and size arithmetic:
  - The payload counter is FLIT_WIDTH bits wide.
  - The N+2 comparison is done in FLIT_WIDTH+1 bits, so N = 2^FLIT_WIDTH-1 does not wrap.
- recv_src_o and recv_nflits_o are latched on entry to DONE and held until ack.
- recv_ack_i is ignored outside DONE.
- Reset behaviour:
  - Reset mid-packet returns the block to IDLE with no writes.
  - The next accepted flit is treated as a header; there is no resynchronisation. The router and the engine are reset together.

## Timing
- Reset values:
  - credit_o=1.
  - mem_wb_o=0, mem_addr_o=0, mem_data_o=0.
  - recv_done_o=0, recv_src_o=0, recv_nflits_o=0.
  - drop_o=0.
- Memory outputs are registered. A flit accepted in cycle t appears on mem_wb_o/mem_addr_o/mem_data_o in cycle t+1, for exactly one cycle. Memory accepts every write; there is no back-pressure.
- Throughput is one flit per cycle in every state except DONE.
- credit_o is 1 in all states except DONE.
- Completion timing: if the last flit is accepted at cycle t, then recv_done_o=1 and credit_o=0 from cycle t+1.
- Ack timing: recv_ack_i sampled high at cycle u gives recv_done_o=0 and credit_o=1 at u+1.
- drop_o is high in the cycle after the final dropped flit is accepted.

## Configuration
- DDMA_RX_DEST_CHECK_EN defined: a header whose dst_xy != ADDRESS is discarded through DROP_SIZE/DROP_BODY.
- DDMA_RX_DEST_CHECK_EN undefined: every header is accepted regardless of dst_xy. The DROP_SIZE path is not generated.

## Structure
- Shared package ddma_rx_pkg holds:
  - the state enum (IDLE, SIZE, PAYLOAD, DONE, DROP_SIZE, DROP_BODY);
  - field-slice helpers for src_xy, dst_xy, X and Y.
- The block is a single module; no sub-module is warranted.

## Test plan
All scenarios use FLIT_WIDTH=32, ADDRESS=256 (X=1,Y=0), BUF_BASE=0, BUF_DEPTH=64.
- Packet 0x00000100, then size 6, then 6 payload flits, sent back-to-back -> 8 writes at addr 0..7, one per cycle, with the data unchanged. recv_done_o=1, recv_nflits_o=8, recv_src_o=0.
- Two packets while recv_ack_i is held low -> credit_o=0 after the first packet and the second packet is stalled. One-cycle ack -> the second packet is accepted and overwrites from addr 0.
- Size flit 0 -> writes at addr 0 and 1 only; recv_done_o=1 with recv_nflits_o=2.
- With DDMA_RX_DEST_CHECK_EN, header 0x00000101, size 3, 3 payload flits -> no writes, drop_o pulses once, recv_done_o stays 0, credit_o stays 1. Without the macro -> the packet is buffered with recv_nflits_o=5.
- Size 63 (65 flits > 64) -> header and size are written at addr 0 and 1 only. All 63 payload flits are consumed, drop_o pulses, no recv_done_o.
- reset asserted after the 3rd payload flit -> outputs return to reset values immediately. A clean packet sent afterwards is received correctly from addr 0.

Source files
------------

// File: rtl/ddma_rx_pkg.sv
// ddma_rx_pkg
// Shared definitions for the DDMA receive engine:
//   - rx_state_e : receive FSM states
//   - src_xy / dst_xy : extract the XY fields from a header flit
//   - xy_x / xy_y : extract the X and Y coordinates from an XY field
// The helpers work on a 64-bit container. FLIT_WIDTH must therefore be
// 64 or less. Callers cast their operands into and out of the container.
package ddma_rx_pkg;

  localparam int unsigned DDMA_MAX_FLIT_WIDTH = 64;
  localparam int unsigned DDMA_MAX_XY_WIDTH   = DDMA_MAX_FLIT_WIDTH / 2;

  typedef logic [DDMA_MAX_FLIT_WIDTH-1:0] ddma_flit_t;
  typedef logic [DDMA_MAX_XY_WIDTH-1:0]   ddma_xy_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SIZE      = 3'd1,
    ST_PAYLOAD   = 3'd2,
    ST_DONE      = 3'd3,
    ST_DROP_SIZE = 3'd4,
    ST_DROP_BODY = 3'd5
  } rx_state_e;

  // Upper half of the header flit is the source XY.
  function automatic ddma_xy_t src_xy(input ddma_flit_t flit, input int unsigned flitWidth);
    ddma_flit_t mask;
    mask = {DDMA_MAX_FLIT_WIDTH{1'b1}} >> (DDMA_MAX_FLIT_WIDTH - flitWidth / 2);
    return ddma_xy_t'((flit >> (flitWidth / 2)) & mask);
  endfunction

  // Lower half of the header flit is the destination XY.
  function automatic ddma_xy_t dst_xy(input ddma_flit_t flit, input int unsigned flitWidth);
    ddma_flit_t mask;
    mask = {DDMA_MAX_FLIT_WIDTH{1'b1}} >> (DDMA_MAX_FLIT_WIDTH - flitWidth / 2);
    return ddma_xy_t'(flit & mask);
  endfunction

  // X is the upper quarter-flit of an XY field.
  function automatic ddma_xy_t xy_x(input ddma_xy_t xy, input int unsigned flitWidth);
    ddma_xy_t mask;
    mask = {DDMA_MAX_XY_WIDTH{1'b1}} >> (DDMA_MAX_XY_WIDTH - flitWidth / 4);
    return (xy >> (flitWidth / 4)) & mask;
  endfunction

  // Y is the lower quarter-flit of an XY field.
  function automatic ddma_xy_t xy_y(input ddma_xy_t xy, input int unsigned flitWidth);
    ddma_xy_t mask;
    mask = {DDMA_MAX_XY_WIDTH{1'b1}} >> (DDMA_MAX_XY_WIDTH - flitWidth / 4);
    return xy & mask;
  endfunction

endpackage

// File: rtl/ddma_rx_engine.sv
// ddma_rx_engine
// Receive-side DMA engine for a processing element's NoC local port.
// The engine parses the header and size flits and writes the whole packet
// into a fixed receive buffer. It then holds the packet and keeps credit
// low until the CPU acknowledges it.
//
// Optional feature macro: DDMA_RX_DEST_CHECK_EN
//   defined   : headers whose dst_xy differs from ADDRESS are discarded.
//   undefined : every header is accepted.
//
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   data_i, rx_i   : incoming flit and its valid
//   credit_o       : ready; a flit transfers when rx_i && credit_o
//   mem_wb_o, mem_addr_o, mem_data_o : registered memory write port
//   recv_done_o    : a complete packet sits in the buffer
//   recv_src_o     : source XY of the buffered packet
//   recv_nflits_o  : flits written (header + size + payload)
//   drop_o         : one-cycle pulse when a packet was discarded
//   recv_ack_i     : CPU releases the buffer
module ddma_rx_engine
  import ddma_rx_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned ADDRESS    = 0,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BUF_BASE   = 0,
  parameter int unsigned BUF_DEPTH  = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [FLIT_WIDTH-1:0]   data_i,
  input  logic                    rx_i,
  output logic                    credit_o,
  output logic                    mem_wb_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [FLIT_WIDTH-1:0]   mem_data_o,
  output logic                    recv_done_o,
  output logic [FLIT_WIDTH/2-1:0] recv_src_o,
  output logic [FLIT_WIDTH-1:0]   recv_nflits_o,
  output logic                    drop_o,
  input  logic                    recv_ack_i
);

  localparam int unsigned HALF = FLIT_WIDTH / 2;
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BUF_BASE);
  localparam logic [FLIT_WIDTH:0]   DEPTH_EXT = (FLIT_WIDTH + 1)'(BUF_DEPTH);

  rx_state_e               r_state;
  logic                    r_credit;
  logic                    r_memWb;
  logic [ADDR_WIDTH-1:0]   r_memAddr;
  logic [FLIT_WIDTH-1:0]   r_memData;
  logic                    r_done;
  logic [HALF-1:0]         r_recvSrc;
  logic [FLIT_WIDTH-1:0]   r_recvNflits;
  logic                    r_drop;
  logic [HALF-1:0]         r_hdrSrc;
  logic [FLIT_WIDTH-1:0]   r_n;
  logic [FLIT_WIDTH-1:0]   r_remain;
  logic [ADDR_WIDTH-1:0]   r_wrAddr;

  logic                    w_accept;
  logic [HALF-1:0]         w_hdrSrc;
  logic                    w_sizeZero;
  logic                    w_tooBig;
  logic                    w_lastFlit;
  logic                    w_destOk;

  assign w_accept   = rx_i && r_credit;
  assign w_hdrSrc   = HALF'(src_xy(DDMA_MAX_FLIT_WIDTH'(data_i), FLIT_WIDTH));
  assign w_sizeZero = (data_i == '0);
  // N+2 is evaluated one bit wider so the largest N cannot wrap into "fits".
  assign w_tooBig   = (({1'b0, data_i} + (FLIT_WIDTH + 1)'(2)) > DEPTH_EXT);
  assign w_lastFlit = (r_remain == FLIT_WIDTH'(1));

`ifdef DDMA_RX_DEST_CHECK_EN
  assign w_destOk = (HALF'(dst_xy(DDMA_MAX_FLIT_WIDTH'(data_i), FLIT_WIDTH)) == HALF'(ADDRESS));
`else
  assign w_destOk = 1'b1;
`endif

  // Receive FSM. All outputs are registered here. The write strobe and the
  // drop pulse default low each cycle, so each one lasts a single cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_credit     <= 1'b1;
      r_memWb      <= 1'b0;
      r_memAddr    <= '0;
      r_memData    <= '0;
      r_done       <= 1'b0;
      r_recvSrc    <= '0;
      r_recvNflits <= '0;
      r_drop       <= 1'b0;
      r_hdrSrc     <= '0;
      r_n          <= '0;
      r_remain     <= '0;
      r_wrAddr     <= '0;
    end else begin
      r_memWb <= 1'b0;
      r_drop  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_destOk) begin
              r_memWb   <= 1'b1;
              r_memAddr <= BASE_ADDR;
              r_memData <= data_i;
              r_hdrSrc  <= w_hdrSrc;
              r_state   <= ST_SIZE;
            end
`ifdef DDMA_RX_DEST_CHECK_EN
            else begin
              r_state <= ST_DROP_SIZE;
            end
`endif
          end
        end
        ST_SIZE: begin
          if (w_accept) begin
            // The size flit is always stored, even for a packet that will be
            // discarded because it does not fit.
            r_memWb   <= 1'b1;
            r_memAddr <= BASE_ADDR + ADDR_WIDTH'(1);
            r_memData <= data_i;
            r_n       <= data_i;
            r_remain  <= data_i;
            r_wrAddr  <= BASE_ADDR + ADDR_WIDTH'(2);
            if (w_sizeZero) begin
              r_state      <= ST_DONE;
              r_done       <= 1'b1;
              r_credit     <= 1'b0;
              r_recvSrc    <= r_hdrSrc;
              r_recvNflits <= FLIT_WIDTH'(2);
            end else if (w_tooBig) begin
              r_state <= ST_DROP_BODY;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_accept) begin
            r_memWb   <= 1'b1;
            r_memAddr <= r_wrAddr;
            r_memData <= data_i;
            r_wrAddr  <= r_wrAddr + ADDR_WIDTH'(1);
            r_remain  <= r_remain - FLIT_WIDTH'(1);
            if (w_lastFlit) begin
              r_state      <= ST_DONE;
              r_done       <= 1'b1;
              r_credit     <= 1'b0;
              r_recvSrc    <= r_hdrSrc;
              r_recvNflits <= r_n + FLIT_WIDTH'(2);
            end
          end
        end
        ST_DONE: begin
          if (recv_ack_i) begin
            r_state  <= ST_IDLE;
            r_done   <= 1'b0;
            r_credit <= 1'b1;
          end
        end
`ifdef DDMA_RX_DEST_CHECK_EN
        ST_DROP_SIZE: begin
          if (w_accept) begin
            if (w_sizeZero) begin
              r_drop  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_remain <= data_i;
              r_state  <= ST_DROP_BODY;
            end
          end
        end
`endif
        ST_DROP_BODY: begin
          if (w_accept) begin
            r_remain <= r_remain - FLIT_WIDTH'(1);
            if (w_lastFlit) begin
              r_drop  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_credit <= 1'b1;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign credit_o      = r_credit;
  assign mem_wb_o      = r_memWb;
  assign mem_addr_o    = r_memAddr;
  assign mem_data_o    = r_memData;
  assign recv_done_o   = r_done;
  assign recv_src_o    = r_recvSrc;
  assign recv_nflits_o = r_recvNflits;
  assign drop_o        = r_drop;

endmodule
